channel_dispense_ctrl: RTL and testbench
========================================

CHANNEL_DISPENSE_CTRL -- requirements
Module: channel_dispense_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- CNT_W, 16, width of every length and cycle counter.
- PRIME_CYC, 8, fixed pump-only priming cycles before dispense.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start_valid  in  1  host requests a dispense run.
- start_ready  out  1  controller accepts a request.
- dispense_len  in  CNT_W  valve-open cycles, sampled on accept.
- timeout_len  in  CNT_W  arrival wait limit in cycles, sampled on accept.
- abort  in  1  synchronous abort request.
- outlet_sense  in  1  outlet detector level, already synchronous to clk.
- valve_open  out  1  inlet sample valve drive.
- pump_en  out  1  carrier pump drive.
- busy  out  1  run in progress.
- done_valid  out  1  result available.
- done_ready  in  1  host consumes the result.
- status  out  2  00 OK, 01 TIMEOUT, 10 ABORT.
- transit_cyc  out  CNT_W  dispense-start-to-arrival cycles.

Function
REQ-003 The FSM SHALL have exactly these states: IDLE, PRIME, DISPENSE, WAIT, REPORT.
REQ-004 start_ready SHALL be 1 only in IDLE; a request is accepted when start_valid and start_ready are both 1, and the FSM then moves to PRIME on the next cycle.
REQ-005 PRIME SHALL last exactly PRIME_CYC cycles, with pump_en=1 and valve_open=0.
REQ-006 DISPENSE SHALL last exactly dispense_len cycles, with pump_en=1 and valve_open=1; if dispense_len=0, PRIME SHALL go directly to WAIT.
REQ-007 WAIT SHALL drive pump_en=1 and valve_open=0, and SHALL exit to REPORT on a rising edge of outlet_sense (status OK) or after timeout_len cycles (status TIMEOUT).
REQ-008 A rising edge SHALL be detected against a registered copy of outlet_sense; edges seen outside WAIT SHALL be ignored.
REQ-009 A sense edge and timeout expiry in the same cycle SHALL resolve to OK.
REQ-010 timeout_len=0 SHALL give TIMEOUT on the first WAIT cycle, unless an edge occurs in that same cycle.
REQ-011 abort=1 in PRIME, DISPENSE or WAIT SHALL, on the next cycle, close the valve, stop the pump, and enter REPORT with status ABORT; abort SHALL be ignored in IDLE and REPORT.
REQ-012 REPORT SHALL hold done_valid=1 with stable status and transit_cyc until done_ready=1, then return to IDLE; pump_en and valve_open SHALL both be 0 in REPORT.
REQ-013 busy SHALL be 1 in PRIME, DISPENSE and WAIT, and 0 otherwise.
REQ-014 All counters SHALL saturate at 2^CNT_W-1 and never wrap.

Reset
REQ-015 While rst_n=0, the following outputs SHALL be forced to 0 immediately, independent of clk: valve_open, pump_en, busy, done_valid, status, transit_cyc. start_ready SHALL be 1 and the FSM SHALL be in IDLE.
REQ-016 Reset asserted mid-run SHALL abandon the run with no REPORT.

Configuration
REQ-017 With macro CHANNEL_DISPENSE_TRANSIT_TIMER_EN defined:
- transit_cyc SHALL count from the first DISPENSE cycle (or the first WAIT cycle if dispense_len=0) up to and including the arrival cycle;
- on TIMEOUT or ABORT, transit_cyc SHALL report the count reached at exit.
REQ-018 Without the macro, the transit counter SHALL not be built and transit_cyc SHALL be constant 0; all other behaviour SHALL be unchanged.

Structure
REQ-019 Shared package channel_ctrl_pkg SHALL hold the state enum, the status code constants and the CNT_W default.
REQ-020 One sub-module, sat_counter (clear, enable, saturating count output), SHALL implement every counter.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- dispense_len=4, timeout_len=20, sense edge on WAIT cycle 5 -> pump on 8+4+5 cycles, valve on exactly 4, status=00, transit_cyc=9.
- dispense_len=3, timeout_len=6, no sense edge -> status=01 after 6 WAIT cycles, transit_cyc=9.
- abort in DISPENSE cycle 2 -> valve and pump 0 on the next cycle, status=10.
- Sense edge coinciding with the timeout cycle -> status=00; dispense_len=0 -> PRIME goes straight to WAIT.
- done_ready held 0 for 10 cycles -> done_valid and outputs stable, start_ready=0; rst_n pulsed in WAIT -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/channel_ctrl_pkg.sv
// Shared definitions for the channel dispense controller: FSM state encoding,
// result status codes and the default counter width.
package channel_ctrl_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRIME    = 3'd1,
    DISPENSE = 3'd2,
    WAIT     = 3'd3,
    REPORT   = 3'd4
  } state_t;

  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b01;
  localparam logic [1:0] STATUS_ABORT   = 2'b10;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Once the count reaches all-ones it holds there instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // clear has priority; enabled counting stops at the all-ones value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/channel_dispense_ctrl.sv
// Channel dispense controller: primes the carrier pump, opens the sample valve
// for a programmed number of cycles, then waits for the sample to reach the
// outlet detector (or times out) and reports the result to the host.
//
// Optional feature macro: CHANNEL_DISPENSE_TRANSIT_TIMER_EN
//   defined   -> transit_cyc counts DISPENSE + WAIT cycles up to and including
//                the exit cycle of the run
//   undefined -> no transit counter is built, transit_cyc is tied to 0
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | ready for a request (start_ready=1), everything off
// PRIME    | pump only for PRIME_CYC cycles
// DISPENSE | pump + valve for dispense_len cycles (skipped when length is 0)
// WAIT     | pump only, waiting for an outlet_sense rising edge or timeout
// REPORT   | done_valid=1 with stable status until done_ready
module channel_dispense_ctrl
  import channel_ctrl_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int PRIME_CYC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [CNT_W-1:0] dispense_len,
  input  logic [CNT_W-1:0] timeout_len,
  input  logic             abort,
  input  logic             outlet_sense,
  output logic             valve_open,
  output logic             pump_en,
  output logic             busy,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] transit_cyc
);

  state_t           state_q, state_d;
  logic [1:0]       status_q, status_d;
  logic [CNT_W-1:0] dlen_q, tlen_q;
  logic             sense_q;
  logic             sense_rise;
  logic             accept;
  logic [CNT_W-1:0] phase_cnt;
  logic             phase_clr;
  logic [CNT_W:0]   phase_inc;
  logic             timeout_hit;

  assign sense_rise  = outlet_sense & ~sense_q;
  // phase_cnt+1 is the number of cycles spent in the current state including
  // this one; the extra bit keeps the compare correct at saturation
  assign phase_inc   = {1'b0, phase_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign timeout_hit = (phase_inc >= {1'b0, tlen_q});
  assign status      = status_q;

  // state, result and sampled-request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      status_q <= STATUS_OK;
      dlen_q   <= '0;
      tlen_q   <= '0;
      sense_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      sense_q  <= outlet_sense;
      if (accept) begin
        dlen_q <= dispense_len;
        tlen_q <= timeout_len;
      end
    end
  end

  // next-state, result selection and output decode
  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    accept      = 1'b0;
    start_ready = 1'b0;
    pump_en     = 1'b0;
    valve_open  = 1'b0;
    busy        = 1'b0;
    done_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          accept   = 1'b1;
          status_d = STATUS_OK;
          state_d  = PRIME;
        end
      end
      PRIME: begin
        pump_en = 1'b1;
        busy    = 1'b1;
        if (abort) begin
          status_d = STATUS_ABORT;
          state_d  = REPORT;
        end else if (phase_cnt == CNT_W'(PRIME_CYC - 1)) begin
          state_d = (dlen_q == '0) ? WAIT : DISPENSE;
        end
      end
      DISPENSE: begin
        pump_en    = 1'b1;
        valve_open = 1'b1;
        busy       = 1'b1;
        if (abort) begin
          status_d = STATUS_ABORT;
          state_d  = REPORT;
        end else if (phase_cnt == (dlen_q - CNT_W'(1))) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        pump_en = 1'b1;
        busy    = 1'b1;
        // abort beats arrival; arrival beats a simultaneous timeout
        if (abort) begin
          status_d = STATUS_ABORT;
          state_d  = REPORT;
        end else if (sense_rise) begin
          status_d = STATUS_OK;
          state_d  = REPORT;
        end else if (timeout_hit) begin
          status_d = STATUS_TIMEOUT;
          state_d  = REPORT;
        end
      end
      REPORT: begin
        done_valid = 1'b1;
        if (done_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // phase_cnt restarts at 0 on every state change, so it always holds the
  // cycle index within the current state
  assign phase_clr = (state_d != state_q);

  sat_counter #(.W(CNT_W)) u_phase_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (phase_clr),
    .en    (busy),
    .cnt   (phase_cnt)
  );

`ifdef CHANNEL_DISPENSE_TRANSIT_TIMER_EN
  logic transit_en;

  // counted through the exit cycle, then frozen for REPORT and IDLE
  assign transit_en = (state_q == DISPENSE) || (state_q == WAIT);

  sat_counter #(.W(CNT_W)) u_transit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (transit_en),
    .cnt   (transit_cyc)
  );
`else
  assign transit_cyc = '0;
`endif

endmodule

// File: tb/tb_channel_dispense_ctrl.sv
// Testbench for channel_dispense_ctrl: directed scenarios followed by random
// runs, each checked against a cycle-count model of a dispense run.
module tb_channel_dispense_ctrl;

  localparam int CNT_W = 16;
  localparam int PRIME = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_valid = 1'b0;
  logic             start_ready;
  logic [CNT_W-1:0] dispense_len = '0;
  logic [CNT_W-1:0] timeout_len = '0;
  logic             abort = 1'b0;
  logic             outlet_sense = 1'b0;
  logic             valve_open;
  logic             pump_en;
  logic             busy;
  logic             done_valid;
  logic             done_ready = 1'b0;
  logic [1:0]       status;
  logic [CNT_W-1:0] transit_cyc;

  int total = 0;
  int bad   = 0;

  channel_dispense_ctrl #(.CNT_W(CNT_W), .PRIME_CYC(PRIME)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .dispense_len (dispense_len),
    .timeout_len  (timeout_len),
    .abort        (abort),
    .outlet_sense (outlet_sense),
    .valve_open   (valve_open),
    .pump_en      (pump_en),
    .busy         (busy),
    .done_valid   (done_valid),
    .done_ready   (done_ready),
    .status       (status),
    .transit_cyc  (transit_cyc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One complete run. The expected result comes from the run's cycle budget:
  // PRIME fixed cycles, dlen valve cycles, then WAIT until the edge or the
  // timeout limit (a zero limit still gives one WAIT cycle); an abort on
  // cycle abort_n (counted from the first PRIME cycle) ends the run there.
  task automatic run(input int dlen, input int tlen, input int edge_k,
                     input int abort_n, input bit pre_pulse, input int hold);
    int waitlim, waitc, run_len, exp_pump, exp_valve, exp_tr, n;
    int pump_c, valve_c, busy_c;
    logic [1:0] exp_st;
    bit tr_known;

    waitlim = (tlen == 0) ? 1 : tlen;
    if (edge_k > 0 && edge_k <= waitlim) begin
      waitc  = edge_k;
      exp_st = 2'b00;
    end else begin
      waitc  = waitlim;
      exp_st = 2'b01;
    end
    run_len = PRIME + dlen + waitc;
    if (abort_n > 0 && abort_n <= run_len) begin
      exp_st    = 2'b10;
      exp_pump  = abort_n;
      exp_valve = (abort_n <= PRIME) ? 0 :
                  ((abort_n - PRIME > dlen) ? dlen : abort_n - PRIME);
      tr_known  = 1'b0;
      exp_tr    = 0;
    end else begin
      exp_pump  = run_len;
      exp_valve = dlen;
      tr_known  = 1'b1;
`ifdef CHANNEL_DISPENSE_TRANSIT_TIMER_EN
      exp_tr    = dlen + waitc;
`else
      exp_tr    = 0;
`endif
    end

    chk("idle_start_ready", 32'(start_ready), 1);
    dispense_len = CNT_W'(dlen);
    timeout_len  = CNT_W'(tlen);
    start_valid  = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    n = 1; pump_c = 0; valve_c = 0; busy_c = 0;
    while (done_valid !== 1'b1 && n < 300) begin
      outlet_sense = (edge_k > 0 && n >= PRIME + dlen + edge_k) || (pre_pulse && n == 2);
      abort        = (abort_n > 0 && n == abort_n);
      if (pump_en === 1'b1)    pump_c++;
      if (valve_open === 1'b1) valve_c++;
      if (busy === 1'b1)       busy_c++;
      @(posedge clk); #1;
      n++;
    end
    abort = 1'b0;
    chk("done_seen", 32'(done_valid), 1);
    chk("pump_cycles", pump_c, exp_pump);
    chk("valve_cycles", valve_c, exp_valve);
    chk("busy_cycles", busy_c, exp_pump);
    chk("status", 32'(status), 32'(exp_st));
    if (tr_known) chk("transit_cyc", 32'(transit_cyc), exp_tr);
    chk("report_pump_off", 32'(pump_en), 0);
    chk("report_valve_off", 32'(valve_open), 0);
    chk("report_busy_off", 32'(busy), 0);
    chk("report_not_ready", 32'(start_ready), 0);

    for (int i = 0; i < hold; i++) begin
      abort = 1'b1;
      @(posedge clk); #1;
      chk("hold_done_valid", 32'(done_valid), 1);
      chk("hold_status", 32'(status), 32'(exp_st));
      if (tr_known) chk("hold_transit", 32'(transit_cyc), exp_tr);
      chk("hold_start_ready", 32'(start_ready), 0);
      chk("hold_pump", 32'(pump_en), 0);
    end
    abort = 1'b0;

    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready   = 1'b0;
    outlet_sense = 1'b0;
    chk("back_idle_ready", 32'(start_ready), 1);
    chk("back_idle_done", 32'(done_valid), 0);
  endtask

  initial begin
    int dl, tl, ek, ab, seen;
    bit pp;

    // reset state
    #12;
    chk("rst_start_ready", 32'(start_ready), 1);
    chk("rst_pump", 32'(pump_en), 0);
    chk("rst_valve", 32'(valve_open), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done_valid), 0);
    chk("rst_status", 32'(status), 0);
    chk("rst_transit", 32'(transit_cyc), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // abort in IDLE is ignored
    abort = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 0);
    chk("idle_abort_ready", 32'(start_ready), 1);
    chk("idle_abort_done", 32'(done_valid), 0);

    run(4, 20, 5, 0, 1'b0, 0);          // arrival on WAIT cycle 5
    run(3, 6, 0, 0, 1'b0, 0);           // timeout after 6 WAIT cycles
    run(4, 20, 0, PRIME + 2, 1'b0, 0);  // abort in DISPENSE cycle 2
    run(2, 5, 5, 0, 1'b0, 0);           // edge on the timeout cycle
    run(0, 10, 3, 0, 1'b0, 0);          // zero dispense length
    run(1, 0, 0, 0, 1'b0, 0);           // zero timeout, no edge
    run(1, 0, 1, 0, 1'b0, 0);           // zero timeout, edge on first WAIT
    run(2, 6, 0, 0, 1'b1, 0);           // edge during PRIME is ignored
    run(0, 4, 0, 3, 1'b0, 0);           // abort in PRIME
    run(3, 10, 2, 0, 1'b0, 10);         // host stalls REPORT for 10 cycles

    // reset pulsed in WAIT: outputs drop immediately, run never reports
    dispense_len = CNT_W'(2);
    timeout_len  = CNT_W'(50);
    start_valid  = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (PRIME + 2 + 3) @(posedge clk);
    #1;
    chk("wait_busy", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pump", 32'(pump_en), 0);
    chk("arst_valve", 32'(valve_open), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done_valid), 0);
    chk("arst_status", 32'(status), 0);
    chk("arst_transit", 32'(transit_cyc), 0);
    chk("arst_ready", 32'(start_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    chk("no_report_after_reset", seen, 0);

    // random runs
    for (int r = 0; r < 20; r++) begin
      dl = $urandom_range(0, 6);
      tl = $urandom_range(0, 8);
      ek = $urandom_range(0, 10);
      pp = 1'($urandom_range(0, 1));
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, PRIME + dl + 3) : 0;
      run(dl, tl, ek, ab, pp, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
